// File: rtl/mem_region_router_pkg.sv
// Shared types for the memory region router.
// FSM states, response codes and default widths.
package mem_router_pkg;

    localparam int DEF_AW = 64;
    localparam int DEF_DW = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_UNMAPPED = 2'd1,
        RSP_IM_WRITE = 2'd2,
        RSP_TIMEOUT  = 2'd3
    } rsp_code_t;

endpackage

// File: rtl/mem_region_router_if.sv
// Core request/response bus plus IM and DM ports.
// slave = router view, master = core/memory view.
interface mem_region_router_if
    import mem_router_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [1:0]    rsp_code;
    logic          im_valid;
    logic          im_ready;
    logic [AW-1:0] im_addr;
    logic          im_rvalid;
    logic [DW-1:0] im_rdata;
    logic          dm_valid;
    logic          dm_ready;
    logic [AW-1:0] dm_addr;
    logic          dm_we;
    logic [DW-1:0] dm_wdata;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_code,
        output im_valid, im_addr,
        input  im_ready, im_rvalid, im_rdata,
        output dm_valid, dm_addr, dm_we, dm_wdata,
        input  dm_ready, dm_rvalid, dm_rdata
    );

    modport master (
        output req_valid, req_addr, req_we, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_code,
        input  im_valid, im_addr,
        output im_ready, im_rvalid, im_rdata,
        input  dm_valid, dm_addr, dm_we, dm_wdata,
        output dm_ready, dm_rvalid, dm_rdata
    );

endinterface

// File: rtl/mem_region_router_region_decode.sv
// Window hit test and window-relative offsets.
// A window with bottom > top never hits.
module region_decode
    import mem_router_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic [AW-1:0] i_addr,
    input  logic [AW-1:0] i_im_bottom,
    input  logic [AW-1:0] i_im_top,
    input  logic [AW-1:0] i_dm_bottom,
    input  logic [AW-1:0] i_dm_top,
    output logic          o_in_im,
    output logic          o_in_dm,
    output logic [AW-1:0] o_im_off,
    output logic [AW-1:0] o_dm_off
);

    assign o_in_im  = (i_addr >= i_im_bottom) && (i_addr <= i_im_top);
    assign o_in_dm  = (i_addr >= i_dm_bottom) && (i_addr <= i_dm_top);
    assign o_im_off = i_addr - i_im_bottom;
    assign o_dm_off = i_addr - i_dm_bottom;

endmodule

// File: rtl/mem_region_router.sv
// Routes one core request at a time to IM or DM by address window.
// Errors: unmapped, IM write, and response timeout.
module mem_region_router
    import mem_router_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          continue_val,
    input  logic [AW-1:0] im_bottom,
    input  logic [AW-1:0] im_top,
    input  logic [AW-1:0] dm_bottom,
    input  logic [AW-1:0] dm_top,
    mem_region_router_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [AW-1:0] r_im_bot;
    logic [AW-1:0] r_im_top;
    logic [AW-1:0] r_dm_bot;
    logic [AW-1:0] r_dm_top;
    logic          r_sel_dm;
    logic [CW-1:0] r_cnt;
    logic          r_im_valid;
    logic [AW-1:0] r_im_addr;
    logic          r_dm_valid;
    logic [AW-1:0] r_dm_addr;
    logic          r_dm_we;
    logic [DW-1:0] r_dm_wdata;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_err;
    rsp_code_t     r_rsp_code;

    logic          w_accept;
    logic          w_in_im;
    logic          w_in_dm;
    logic [AW-1:0] w_im_off;
    logic [AW-1:0] w_dm_off;
    logic          w_hs;
    logic          w_rvalid;
    logic [DW-1:0] w_rdata;
    logic          w_expire;

    region_decode #(.AW(AW)) u_dec (
        .i_addr      (r_addr),
        .i_im_bottom (r_im_bot),
        .i_im_top    (r_im_top),
        .i_dm_bottom (r_dm_bot),
        .i_dm_top    (r_dm_top),
        .o_in_im     (w_in_im),
        .o_in_dm     (w_in_dm),
        .o_im_off    (w_im_off),
        .o_dm_off    (w_dm_off)
    );

    assign bus.req_ready = (r_state == S_IDLE) && continue_val;
    assign w_accept = bus.req_valid && bus.req_ready;

    assign w_hs = r_sel_dm ? (r_dm_valid && bus.dm_ready)
                           : (r_im_valid && bus.im_ready);
    assign w_rvalid = r_sel_dm ? bus.dm_rvalid : bus.im_rvalid;
    assign w_rdata  = r_sel_dm ? bus.dm_rdata : bus.im_rdata;
    assign w_expire = (r_cnt == CNT_LAST);

    assign bus.im_valid  = r_im_valid;
    assign bus.im_addr   = r_im_addr;
    assign bus.dm_valid  = r_dm_valid;
    assign bus.dm_addr   = r_dm_addr;
    assign bus.dm_we     = r_dm_we;
    assign bus.dm_wdata  = r_dm_wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_code  = r_rsp_code;

    // Request FSM with registered port and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_im_bot    <= '0;
            r_im_top    <= '0;
            r_dm_bot    <= '0;
            r_dm_top    <= '0;
            r_sel_dm    <= 1'b0;
            r_cnt       <= '0;
            r_im_valid  <= 1'b0;
            r_im_addr   <= '0;
            r_dm_valid  <= 1'b0;
            r_dm_addr   <= '0;
            r_dm_we     <= 1'b0;
            r_dm_wdata  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_code  <= RSP_OK;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= bus.req_addr;
                        r_we     <= bus.req_we;
                        r_wdata  <= bus.req_wdata;
                        r_im_bot <= im_bottom;
                        r_im_top <= im_top;
                        r_dm_bot <= dm_bottom;
                        r_dm_top <= dm_top;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_cnt <= '0;
                    if (w_in_im && r_we) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_code  <= RSP_IM_WRITE;
                        r_rsp_data  <= '0;
                        r_state     <= S_RESP;
                    end else if (w_in_im) begin
                        r_sel_dm   <= 1'b0;
                        r_im_valid <= 1'b1;
                        r_im_addr  <= w_im_off;
                        r_state    <= S_ISSUE;
                    end else if (w_in_dm) begin
                        r_sel_dm   <= 1'b1;
                        r_dm_valid <= 1'b1;
                        r_dm_addr  <= w_dm_off;
                        r_dm_we    <= r_we;
                        r_dm_wdata <= r_wdata;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_code  <= RSP_UNMAPPED;
                        r_rsp_data  <= '0;
                        r_state     <= S_RESP;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_expire || w_hs) begin
                        r_im_valid <= 1'b0;
                        r_im_addr  <= '0;
                        r_dm_valid <= 1'b0;
                        r_dm_addr  <= '0;
                        r_dm_we    <= 1'b0;
                        r_dm_wdata <= '0;
                    end
                    if (w_expire) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_code  <= RSP_TIMEOUT;
                        r_rsp_data  <= '0;
                        r_state     <= S_RESP;
                    end else if (w_hs) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_rvalid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_code  <= RSP_OK;
                        r_rsp_data  <= r_we ? '0 : w_rdata;
                        r_state     <= S_RESP;
                    end else if (w_expire) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_code  <= RSP_TIMEOUT;
                        r_rsp_data  <= '0;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_code  <= RSP_OK;
                    r_rsp_data  <= '0;
                    r_cnt       <= '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_region_router;
    import mem_router_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 16;
    localparam logic [AW-1:0] IM_B = 64'h0;
    localparam logic [AW-1:0] IM_T = 64'h7_FFFF_FFFF;
    localparam logic [AW-1:0] DM_B = 64'h8_0000_0000;
    localparam logic [AW-1:0] DM_T = 64'hF_FFFF_FFFF;

    typedef struct {
        logic [AW-1:0] ib, it, db, dt, addr;
        int            tgt;
        logic [AW-1:0] off;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          continue_val;
    logic [AW-1:0] im_bottom, im_top, dm_bottom, dm_top;
    int            errors = 0;
    int            checks = 0;

    mem_region_router_if #(.AW(AW), .DW(DW)) bus ();

    mem_region_router #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .continue_val (continue_val),
        .im_bottom    (im_bottom),
        .im_top       (im_top),
        .dm_bottom    (dm_bottom),
        .dm_top       (dm_top),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_map(input logic [AW-1:0] ib, it, db, dt);
        im_bottom = ib; im_top = it; dm_bottom = db; dm_top = dt;
    endtask

    // Presents a request while IDLE; returns in DECODE
    task automatic drive_req(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_we = we; bus.req_wdata = d;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; continue_val = 1'b1;
        tick(); tick();
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%0h exp=1", bus.req_ready); end
        checks++; if (bus.im_valid !== 1'b0) begin errors++; $display("FAIL rst_im_valid got=%0h exp=0", bus.im_valid); end
        checks++; if (bus.dm_valid !== 1'b0) begin errors++; $display("FAIL rst_dm_valid got=%0h exp=0", bus.dm_valid); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%0h exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_code !== 2'd0) begin errors++; $display("FAIL rst_rsp_code got=%0h exp=0", bus.rsp_code); end
        checks++; if (bus.dm_we !== 1'b0) begin errors++; $display("FAIL rst_dm_we got=%0h exp=0", bus.dm_we); end
        continue_val = 1'b0; #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_cont got=%0h exp=0", bus.req_ready); end
        continue_val = 1'b1; reset = 1'b0;
        tick();
    endtask

    task automatic test_im_read();
        drive_req(64'h1000, 1'b0, '0);
        im_bottom = 64'h800;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_busy got=%0h exp=0", bus.req_ready); end
        tick();
        checks++; if (bus.im_valid !== 1'b1) begin errors++; $display("FAIL rd_im_valid got=%0h exp=1", bus.im_valid); end
        checks++; if (bus.im_addr !== 64'h1000) begin errors++; $display("FAIL rd_im_addr got=%0h exp=1000", bus.im_addr); end
        checks++; if (bus.dm_valid !== 1'b0) begin errors++; $display("FAIL rd_dm_valid got=%0h exp=0", bus.dm_valid); end
        tick();
        checks++; if (bus.im_valid !== 1'b1) begin errors++; $display("FAIL rd_hold got=%0h exp=1", bus.im_valid); end
        bus.im_ready = 1'b1; tick(); bus.im_ready = 1'b0;
        checks++; if (bus.im_valid !== 1'b0) begin errors++; $display("FAIL rd_im_drop got=%0h exp=0", bus.im_valid); end
        im_bottom = IM_B;
        tick(); tick();
        bus.im_rvalid = 1'b1; bus.im_rdata = 64'hDEAD_BEEF;
        tick();
        bus.im_rvalid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid got=%0h exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp_data got=%0h exp=deadbeef", bus.rsp_data); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp_err got=%0h exp=0", bus.rsp_err); end
        checks++; if (bus.rsp_code !== RSP_OK) begin errors++; $display("FAIL rd_rsp_code got=%0h exp=0", bus.rsp_code); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_pulse got=%0h exp=0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_back got=%0h exp=1", bus.req_ready); end
    endtask

    task automatic test_dm_write();
        drive_req(64'h8_0000_0010, 1'b1, 64'h55);
        tick();
        checks++; if (bus.dm_valid !== 1'b1) begin errors++; $display("FAIL wr_dm_valid got=%0h exp=1", bus.dm_valid); end
        checks++; if (bus.dm_addr !== 64'h10) begin errors++; $display("FAIL wr_dm_addr got=%0h exp=10", bus.dm_addr); end
        checks++; if (bus.dm_we !== 1'b1) begin errors++; $display("FAIL wr_dm_we got=%0h exp=1", bus.dm_we); end
        checks++; if (bus.dm_wdata !== 64'h55) begin errors++; $display("FAIL wr_dm_wdata got=%0h exp=55", bus.dm_wdata); end
        checks++; if (bus.im_valid !== 1'b0) begin errors++; $display("FAIL wr_im_valid got=%0h exp=0", bus.im_valid); end
        bus.dm_ready = 1'b1; tick(); bus.dm_ready = 1'b0;
        checks++; if (bus.dm_valid !== 1'b0) begin errors++; $display("FAIL wr_dm_drop got=%0h exp=0", bus.dm_valid); end
        bus.im_rvalid = 1'b1; bus.im_rdata = 64'h9999;
        tick();
        bus.im_rvalid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_ignore_im got=%0h exp=0", bus.rsp_valid); end
        bus.dm_rvalid = 1'b1; bus.dm_rdata = 64'hFFFF;
        tick();
        bus.dm_rvalid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid got=%0h exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 64'h0) begin errors++; $display("FAIL wr_rsp_data got=%0h exp=0", bus.rsp_data); end
        checks++; if (bus.rsp_code !== RSP_OK) begin errors++; $display("FAIL wr_rsp_code got=%0h exp=0", bus.rsp_code); end
        tick();
    endtask

    task automatic test_errors();
        drive_req(64'h10_0000_0000, 1'b0, '0);
        tick();
        checks++; if (bus.im_valid !== 1'b0 || bus.dm_valid !== 1'b0) begin errors++; $display("FAIL um_no_issue got=%0h%0h exp=00", bus.im_valid, bus.dm_valid); end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL um_rsp_valid got=%0h exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL um_rsp_err got=%0h exp=1", bus.rsp_err); end
        checks++; if (bus.rsp_code !== RSP_UNMAPPED) begin errors++; $display("FAIL um_rsp_code got=%0h exp=1", bus.rsp_code); end
        checks++; if (bus.rsp_data !== 64'h0) begin errors++; $display("FAIL um_rsp_data got=%0h exp=0", bus.rsp_data); end
        tick();
        drive_req(64'h100, 1'b1, 64'hAA);
        tick();
        checks++; if (bus.im_valid !== 1'b0) begin errors++; $display("FAIL imw_im_valid got=%0h exp=0", bus.im_valid); end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL imw_rsp_valid got=%0h exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_code !== RSP_IM_WRITE) begin errors++; $display("FAIL imw_rsp_code got=%0h exp=2", bus.rsp_code); end
        checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL imw_rsp_err got=%0h exp=1", bus.rsp_err); end
        tick();
    endtask

    // tgt: 0 = IM, 1 = DM, 2 = unmapped
    task automatic test_decode_table();
        vec_t v[7];
        v[0] = '{IM_B, IM_T, DM_B, DM_T, 64'h7_FFFF_FFFF, 0, 64'h7_FFFF_FFFF};
        v[1] = '{IM_B, IM_T, DM_B, DM_T, 64'h8_0000_0000, 1, 64'h0};
        v[2] = '{IM_B, IM_T, DM_B, DM_T, 64'hF_FFFF_FFFF, 1, 64'h7_FFFF_FFFF};
        v[3] = '{64'h1000, 64'h1FFF, 64'h0, 64'hFFFF, 64'h1800, 0, 64'h800};
        v[4] = '{64'h1000, 64'h1FFF, 64'h0, 64'hFFFF, 64'h2000, 1, 64'h2000};
        v[5] = '{64'h100, 64'hFF, 64'h200, 64'h2FF, 64'h100, 2, 64'h0};
        v[6] = '{64'h100, 64'h1FF, 64'h200, 64'h2FF, 64'hFF, 2, 64'h0};
        for (int i = 0; i < 7; i++) begin
            set_map(v[i].ib, v[i].it, v[i].db, v[i].dt);
            drive_req(v[i].addr, 1'b0, '0);
            tick();
            checks++; if (bus.im_valid !== (v[i].tgt == 0)) begin errors++; $display("FAIL dec%0d_im_valid got=%0h", i, bus.im_valid); end
            checks++; if (bus.dm_valid !== (v[i].tgt == 1)) begin errors++; $display("FAIL dec%0d_dm_valid got=%0h", i, bus.dm_valid); end
            checks++; if (bus.rsp_valid !== (v[i].tgt == 2)) begin errors++; $display("FAIL dec%0d_rsp_valid got=%0h", i, bus.rsp_valid); end
            if (v[i].tgt == 0) begin
                checks++; if (bus.im_addr !== v[i].off) begin errors++; $display("FAIL dec%0d_im_addr got=%0h exp=%0h", i, bus.im_addr, v[i].off); end
                bus.im_ready = 1'b1; tick(); bus.im_ready = 1'b0;
                bus.im_rvalid = 1'b1; tick(); bus.im_rvalid = 1'b0;
                tick();
            end else if (v[i].tgt == 1) begin
                checks++; if (bus.dm_addr !== v[i].off) begin errors++; $display("FAIL dec%0d_dm_addr got=%0h exp=%0h", i, bus.dm_addr, v[i].off); end
                bus.dm_ready = 1'b1; tick(); bus.dm_ready = 1'b0;
                bus.dm_rvalid = 1'b1; tick(); bus.dm_rvalid = 1'b0;
                tick();
            end else begin
                checks++; if (bus.rsp_code !== RSP_UNMAPPED) begin errors++; $display("FAIL dec%0d_code got=%0h exp=1", i, bus.rsp_code); end
                tick();
            end
        end
        set_map(IM_B, IM_T, DM_B, DM_T);
    endtask

    task automatic test_timeout();
        bus.dm_ready = 1'b1;
        drive_req(64'h8_0000_0020, 1'b0, '0);
        tick();
        checks++; if (bus.dm_valid !== 1'b1) begin errors++; $display("FAIL to_dm_valid got=%0h exp=1", bus.dm_valid); end
        tick();
        bus.dm_ready = 1'b0;
        checks++; if (bus.dm_valid !== 1'b0) begin errors++; $display("FAIL to_dm_drop got=%0h exp=0", bus.dm_valid); end
        repeat (14) tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early got=%0h exp=0", bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL to_rsp_valid got=%0h exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_code !== RSP_TIMEOUT) begin errors++; $display("FAIL to_rsp_code got=%0h exp=3", bus.rsp_code); end
        checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL to_rsp_err got=%0h exp=1", bus.rsp_err); end
        tick();
        drive_req(64'h8_0000_0028, 1'b0, '0);
        tick();
        repeat (15) tick();
        checks++; if (bus.dm_valid !== 1'b1) begin errors++; $display("FAIL tor_hold got=%0h exp=1", bus.dm_valid); end
        tick();
        checks++; if (bus.dm_valid !== 1'b0) begin errors++; $display("FAIL tor_drop got=%0h exp=0", bus.dm_valid); end
        checks++; if (bus.rsp_code !== RSP_TIMEOUT || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL tor_code got=%0h/%0h exp=3/1", bus.rsp_code, bus.rsp_valid); end
        tick();
        bus.dm_ready = 1'b1;
        drive_req(64'h8_0000_0030, 1'b0, '0);
        tick(); tick();
        bus.dm_ready = 1'b0;
        repeat (14) tick();
        bus.dm_rvalid = 1'b1; bus.dm_rdata = 64'hABCD;
        tick();
        bus.dm_rvalid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL race_rsp_valid got=%0h exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_code !== RSP_OK) begin errors++; $display("FAIL race_code got=%0h exp=0", bus.rsp_code); end
        checks++; if (bus.rsp_data !== 64'hABCD) begin errors++; $display("FAIL race_data got=%0h exp=abcd", bus.rsp_data); end
        tick();
    endtask

    task automatic test_continue();
        continue_val = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 64'h2000; bus.req_we = 1'b0;
        repeat (3) tick();
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL cv_ready got=%0h exp=0", bus.req_ready); end
        checks++; if (bus.im_valid !== 1'b0) begin errors++; $display("FAIL cv_no_issue got=%0h exp=0", bus.im_valid); end
        continue_val = 1'b1; #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL cv_ready_up got=%0h exp=1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++; if (bus.im_valid !== 1'b1 || bus.im_addr !== 64'h2000) begin errors++; $display("FAIL cv_issue got=%0h/%0h exp=1/2000", bus.im_valid, bus.im_addr); end
        continue_val = 1'b0;
        bus.im_ready = 1'b1; tick(); bus.im_ready = 1'b0;
        bus.im_rvalid = 1'b1; bus.im_rdata = 64'h1234;
        tick();
        bus.im_rvalid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h1234) begin errors++; $display("FAIL cv_complete got=%0h/%0h exp=1/1234", bus.rsp_valid, bus.rsp_data); end
        tick();
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL cv_blocked got=%0h exp=0", bus.req_ready); end
        continue_val = 1'b1;
    endtask

    task automatic test_reset_mid();
        bus.dm_ready = 1'b1;
        drive_req(64'h8_0000_0040, 1'b0, '0);
        tick();
        checks++; if (bus.dm_valid !== 1'b1) begin errors++; $display("FAIL rm_dm_valid got=%0h exp=1", bus.dm_valid); end
        tick();
        bus.dm_ready = 1'b0;
        reset = 1'b1; bus.dm_rvalid = 1'b1;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rsp_valid got=%0h exp=0", bus.rsp_valid); end
        checks++; if (bus.im_valid !== 1'b0 || bus.dm_valid !== 1'b0) begin errors++; $display("FAIL rm_valids got=%0h%0h exp=00", bus.im_valid, bus.dm_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rm_idle got=%0h exp=1", bus.req_ready); end
        reset = 1'b0; bus.dm_rvalid = 1'b0;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_rsp got=%0h exp=0", bus.rsp_valid); end
        drive_req(64'h40, 1'b0, '0);
        tick();
        checks++; if (bus.im_valid !== 1'b1 || bus.im_addr !== 64'h40) begin errors++; $display("FAIL rm_fresh_issue got=%0h/%0h exp=1/40", bus.im_valid, bus.im_addr); end
        bus.im_ready = 1'b1; tick(); bus.im_ready = 1'b0;
        bus.im_rvalid = 1'b1; bus.im_rdata = 64'h77;
        tick();
        bus.im_rvalid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h77) begin errors++; $display("FAIL rm_fresh_rsp got=%0h/%0h exp=1/77", bus.rsp_valid, bus.rsp_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.im_ready = 1'b1; bus.im_rvalid = 1'b1; bus.im_rdata = 64'h1111;
        bus.req_valid = 1'b1; bus.req_addr = 64'h100; bus.req_we = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (bus.rsp_valid !== 1'b1 && lat < 20);
        checks++; if (lat != 4) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=4", lat); end
        checks++; if (bus.rsp_data !== 64'h1111) begin errors++; $display("FAIL b2b_data1 got=%0h exp=1111", bus.rsp_data); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_resp got=%0h exp=0", bus.req_ready); end
        bus.req_addr = 64'h108; bus.im_rdata = 64'h2222;
        tick();
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got=%0h exp=1", bus.req_ready); end
        lat = 0;
        do begin tick(); lat++; end while (bus.rsp_valid !== 1'b1 && lat < 20);
        checks++; if (lat != 4) begin errors++; $display("FAIL b2b_lat2 got=%0d exp=4", lat); end
        checks++; if (bus.rsp_data !== 64'h2222) begin errors++; $display("FAIL b2b_data2 got=%0h exp=2222", bus.rsp_data); end
        bus.req_valid = 1'b0; bus.im_ready = 1'b0; bus.im_rvalid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; continue_val = 1'b1;
        set_map(IM_B, IM_T, DM_B, DM_T);
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0; bus.req_wdata = '0;
        bus.im_ready = 1'b0; bus.im_rvalid = 1'b0; bus.im_rdata = '0;
        bus.dm_ready = 1'b0; bus.dm_rvalid = 1'b0; bus.dm_rdata = '0;
        test_reset();
        test_im_read();
        test_dm_write();
        test_errors();
        test_decode_table();
        test_timeout();
        test_continue();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
